// File: rtl/dfd_te_pkg.sv
// Shared trace-encoder types for the MSEO/MDO packers.
package dfd_te_pkg;

  localparam int MSO_BITS = 2;

  typedef enum logic [1:0] {
    MSEO_NORM = 2'b00,
    MSEO_VAR  = 2'b01,
    MSEO_LAST = 2'b11
  } mseo_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } te_mso_pk_state_e;

endpackage

// File: rtl/dfd_te_mso_packer_if.sv
// Field-in / beat-out handshake bundle for dfd_te_mso_packer.
// master = message builder + sink side, slave = the packer.
interface dfd_te_mso_packer_if
  import dfd_te_pkg::*;
#(
  parameter int MDO_BITS   = 6,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_BYTES  = 8,
  parameter int BUF_BYTES  = 32
);
  localparam int MSG_BITS = MDO_BITS + MSO_BITS;

  logic                               in_valid;
  logic                               in_ready;
  logic [DATA_WIDTH-1:0]              in_data;
  logic [$clog2(DATA_WIDTH):0]        in_len;
  logic                               in_is_var;
  logic                               in_is_last;
  logic                               flush_req;
  logic                               out_valid;
  logic                               out_ready;
  logic [OUT_BYTES*MSG_BITS-1:0]      out_data;
  logic [OUT_BYTES-1:0]               out_be;
  logic [$clog2(OUT_BYTES):0]         out_len;
  logic                               out_last;
  logic [$clog2(BUF_BYTES):0]         buf_count;

  modport master (
    output in_valid, in_data, in_len, in_is_var, in_is_last, flush_req, out_ready,
    input  in_ready, out_valid, out_data, out_be, out_len, out_last, buf_count
  );

  modport slave (
    input  in_valid, in_data, in_len, in_is_var, in_is_last, flush_req, out_ready,
    output in_ready, out_valid, out_data, out_be, out_len, out_last, buf_count
  );

endinterface

// File: rtl/dfd_te_mso_field_enc.sv
// Combinational MSEO/MDO field encoder: one field in, up to MAX_FIELD_BYTES
// encoded bytes out (MDO in the upper bits, MSEO in the lower two bits),
// plus the byte count and the position of the MSEO=11 byte.
module dfd_te_mso_field_enc
  import dfd_te_pkg::*;
#(
  parameter  int MDO_BITS        = 6,
  parameter  int DATA_WIDTH      = 64,
  localparam int MSG_BITS        = MDO_BITS + MSO_BITS,
  localparam int MAX_FIELD_BYTES = (DATA_WIDTH + MDO_BITS - 1) / MDO_BITS,
  localparam int LEN_W           = $clog2(DATA_WIDTH) + 1,
  localparam int NB_W            = $clog2(MAX_FIELD_BYTES + 1)
) (
  input  logic [DATA_WIDTH-1:0]                     data,
  input  logic [LEN_W-1:0]                          len,
  input  logic                                      is_var,
  input  logic                                      is_last,
  output logic [MAX_FIELD_BYTES-1:0][MSG_BITS-1:0]  bytes,
  output logic [NB_W-1:0]                           n_bytes,
  output logic                                      eom,
  output logic [NB_W-1:0]                           eom_pos
);

  localparam int PAD_W = MAX_FIELD_BYTES * MDO_BITS;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] n_calc;
  logic [PAD_W-1:0] padded;
  logic [1:0]       term;
  logic [1:0]       mseo_k;

  // Clamp the length, mask unused data bits and slice into MDO groups.
  always_comb begin
    eff_len = (len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : len;
    padded  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      padded[i] = data[i] & (i < int'(eff_len));
    end
    n_calc = (eff_len + LEN_W'(MDO_BITS - 1)) / LEN_W'(MDO_BITS);
    // A zero-length terminator still needs a byte to carry its MSEO code.
    if ((eff_len == '0) && (is_last || is_var)) begin
      n_calc = LEN_W'(1);
    end
    if (is_last) begin
      term = MSEO_LAST;
    end else if (is_var) begin
      term = MSEO_VAR;
    end else begin
      term = MSEO_NORM;
    end
    mseo_k = MSEO_NORM;
    bytes  = '0;
    for (int k = 0; k < MAX_FIELD_BYTES; k++) begin
      mseo_k   = (LEN_W'(k + 1) == n_calc) ? term : MSEO_NORM;
      bytes[k] = {padded[k*MDO_BITS +: MDO_BITS], mseo_k};
    end
    n_bytes = NB_W'(n_calc);
    eom     = is_last;
    eom_pos = NB_W'(n_calc - LEN_W'(1));
  end

endmodule

// File: rtl/dfd_te_mso_packer.sv
// MSEO/MDO trace packer: encodes one field per handshake into a circular
// byte buffer and emits OUT_BYTES-wide beats with valid/ready backpressure.
// A message end (MSEO=11 byte) always closes a beat.
// Build option: DFD_TE_MSO_IDLE_FILL_EN pads short beats with idle bytes
// {MDO=0, MSEO=11} and reports them as full width.
module dfd_te_mso_packer
  import dfd_te_pkg::*;
#(
  parameter int MDO_BITS   = 6,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_BYTES  = 8,
  parameter int BUF_BYTES  = 32   // power of two, >= MAX_FIELD_BYTES + OUT_BYTES
) (
  input logic                clk,
  input logic                reset_n,
  dfd_te_mso_packer_if.slave bus
);

  localparam int MSG_BITS        = MDO_BITS + MSO_BITS;
  localparam int MAX_FIELD_BYTES = (DATA_WIDTH + MDO_BITS - 1) / MDO_BITS;
  localparam int PTR_W           = $clog2(BUF_BYTES);
  localparam int CNT_W           = PTR_W + 1;
  localparam int OLEN_W          = $clog2(OUT_BYTES) + 1;
  localparam int NB_W            = $clog2(MAX_FIELD_BYTES + 1);
  localparam logic [CNT_W-1:0] IN_LIMIT = CNT_W'(BUF_BYTES - MAX_FIELD_BYTES);
`ifdef DFD_TE_MSO_IDLE_FILL_EN
  localparam logic [MSG_BITS-1:0] IDLE_BYTE = {{MDO_BITS{1'b0}}, 2'b11};
`endif

  logic [BUF_BYTES-1:0][MSG_BITS-1:0]       mem;
  logic [BUF_BYTES-1:0]                     eom_tag;
  logic [PTR_W-1:0]                         wr_ptr;
  logic [PTR_W-1:0]                         rd_ptr;
  logic [CNT_W-1:0]                         count;
  logic [CNT_W-1:0]                         count_next;
  te_mso_pk_state_e                         state;
  logic                                     in_ready_q;

  logic [MAX_FIELD_BYTES-1:0][MSG_BITS-1:0] enc_bytes;
  logic [NB_W-1:0]                          enc_n;
  logic                                     enc_eom;
  logic [NB_W-1:0]                          enc_eom_pos;

  logic                                     push;
  logic                                     pop;
  logic [OUT_BYTES-1:0][MSG_BITS-1:0]       win;
  logic [OUT_BYTES-1:0]                     win_eom;
  logic                                     eom_found;
  logic [OLEN_W-1:0]                        beat_len;
  logic                                     beat_valid;

  dfd_te_mso_field_enc #(
    .MDO_BITS   (MDO_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_enc (
    .data    (bus.in_data),
    .len     (bus.in_len),
    .is_var  (bus.in_is_var),
    .is_last (bus.in_is_last),
    .bytes   (enc_bytes),
    .n_bytes (enc_n),
    .eom     (enc_eom),
    .eom_pos (enc_eom_pos)
  );

  assign push       = bus.in_valid && in_ready_q;
  assign pop        = beat_valid && bus.out_ready;
  assign count_next = count + (push ? CNT_W'(enc_n) : CNT_W'(0))
                            - (pop  ? CNT_W'(beat_len) : CNT_W'(0));

  // Look at the head of the buffer and size the next beat from registered state.
  always_comb begin
    win     = '0;
    win_eom = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (CNT_W'(i) < count) begin
        win[i]     = mem[rd_ptr + PTR_W'(i)];
        win_eom[i] = eom_tag[rd_ptr + PTR_W'(i)];
      end
    end
    eom_found = 1'b0;
    beat_len  = (count >= CNT_W'(OUT_BYTES)) ? OLEN_W'(OUT_BYTES) : OLEN_W'(count);
    // Descending scan so the lowest eom position wins.
    for (int i = OUT_BYTES - 1; i >= 0; i--) begin
      if (win_eom[i]) begin
        eom_found = 1'b1;
        beat_len  = OLEN_W'(i + 1);
      end
    end
    beat_valid = (count >= CNT_W'(OUT_BYTES)) || eom_found ||
                 ((state == FLUSH) && (count != '0));
  end

  // Drive the beat; everything is zero while no beat is offered.
  always_comb begin
    bus.out_valid = beat_valid;
    bus.out_last  = beat_valid && eom_found;
    bus.out_data  = '0;
    bus.out_be    = '0;
    bus.out_len   = '0;
    if (beat_valid) begin
      for (int i = 0; i < OUT_BYTES; i++) begin
        if (OLEN_W'(i) < beat_len) begin
          bus.out_data[i*MSG_BITS +: MSG_BITS] = win[i];
          bus.out_be[i]                        = 1'b1;
        end
`ifdef DFD_TE_MSO_IDLE_FILL_EN
        else begin
          bus.out_data[i*MSG_BITS +: MSG_BITS] = IDLE_BYTE;
          bus.out_be[i]                        = 1'b1;
        end
`endif
      end
`ifdef DFD_TE_MSO_IDLE_FILL_EN
      bus.out_len = OLEN_W'(OUT_BYTES);
`else
      bus.out_len = beat_len;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.buf_count = count;

  // Store the encoded bytes of an accepted field; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < MAX_FIELD_BYTES; k++) begin
        if (NB_W'(k) < enc_n) begin
          mem[wr_ptr + PTR_W'(k)]     <= enc_bytes[k];
          eom_tag[wr_ptr + PTR_W'(k)] <= enc_eom && (NB_W'(k) == enc_eom_pos);
        end
      end
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(enc_n);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(beat_len);
      count <= count_next;
    end
  end

  // Sequencing FSM with registered in_ready (low in reset and throughout FLUSH).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state      <= FLUSH;
            in_ready_q <= 1'b0;
          end else begin
            if (push && (enc_n != '0)) state <= ACCUM;
            in_ready_q <= (count_next <= IN_LIMIT);
          end
        end
        ACCUM: begin
          if (bus.flush_req) begin
            state      <= FLUSH;
            in_ready_q <= 1'b0;
          end else begin
            if (count_next == '0) state <= IDLE;
            in_ready_q <= (count_next <= IN_LIMIT);
          end
        end
        FLUSH: begin
          if (count_next == '0) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfd_te_mso_packer.sv
// Self-checking bench for dfd_te_mso_packer: a table of single-message
// vectors plus hand-written multi-cycle sequences (flush, backpressure with
// pointer wrap, reset mid-stream).
`timescale 1ns/1ps
module tb_dfd_te_mso_packer;

  localparam int DW  = 64;
  localparam int MDO = 6;
  localparam int OB  = 8;
  localparam int BB  = 32;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FC8  = 64'hFCFC_FCFC_FCFC_FCFC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dfd_te_mso_packer_if #(.MDO_BITS(MDO), .DATA_WIDTH(DW), .OUT_BYTES(OB), .BUF_BYTES(BB)) bus ();

  dfd_te_mso_packer #(.MDO_BITS(MDO), .DATA_WIDTH(DW), .OUT_BYTES(OB), .BUF_BYTES(BB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string        name;
    int           len;
    logic [63:0]  data;
    logic         is_var;
    logic         is_last;
    logic [63:0]  exp_data;
    logic [3:0]   exp_len;
    logic [7:0]   exp_be;
    logic         exp_last;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int len, input logic [63:0] d, input logic v, input logic l);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else begin
      bus.in_valid   = 1'b1;
      bus.in_len     = 7'(len);
      bus.in_data    = d;
      bus.in_is_var  = v;
      bus.in_is_last = l;
      @(negedge clk);
      bus.in_valid   = 1'b0;
    end
  endtask

  task automatic get_beat(input string name, input logic [63:0] d, input logic [3:0] l,
                          input logic [7:0] be, input logic lst);
    int n = 0;
`ifdef DFD_TE_MSO_IDLE_FILL_EN
    for (int i = int'(l); i < OB; i++) d[i*8 +: 8] = 8'h03;
    l  = 4'(OB);
    be = 8'hFF;
`endif
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: out_valid stayed 0, expected 1", name);
    end else begin
      check({name, "_data"}, bus.out_data, d);
      check({name, "_len"},  64'(bus.out_len), 64'(l));
      check({name, "_be"},   64'(bus.out_be), 64'(be));
      check({name, "_last"}, 64'(bus.out_last), 64'(lst));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{"short6",        6,  64'h2A,  1'b0, 1'b1, 64'hAB,   4'd1, 8'h01, 1'b1};
    vecs[1] = '{"mask3",         3,  64'hFF,  1'b0, 1'b1, 64'h1F,   4'd1, 8'h01, 1'b1};
    vecs[2] = '{"two_byte",      12, 64'hABC, 1'b0, 1'b1, 64'hABF0, 4'd2, 8'h03, 1'b1};
    vecs[3] = '{"zero_last",     0,  64'h0,   1'b0, 1'b1, 64'h03,   4'd1, 8'h01, 1'b1};
    vecs[4] = '{"last_over_var", 8,  64'h1FF, 1'b1, 1'b1, 64'h0FFC, 4'd2, 8'h03, 1'b1};
    vecs[5] = '{"seven",         7,  64'h7F,  1'b0, 1'b1, 64'h07FC, 4'd2, 8'h03, 1'b1};
    vecs[6] = '{"full_beat",     48, ONES,    1'b0, 1'b1, 64'hFFFC_FCFC_FCFC_FCFC, 4'd8, 8'hFF, 1'b1};

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_len     = '0;
    bus.in_is_var  = 1'b0;
    bus.in_is_last = 1'b0;
    bus.flush_req  = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  bus.out_data, 64'd0);
    check("rst_out_be",    64'(bus.out_be), 64'd0);
    check("rst_out_len",   64'(bus.out_len), 64'd0);
    check("rst_out_last",  64'(bus.out_last), 64'd0);
    check("rst_buf_count", 64'(bus.buf_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single-message vectors.
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].len, vecs[i].data, vecs[i].is_var, vecs[i].is_last);
      get_beat(vecs[i].name, vecs[i].exp_data, vecs[i].exp_len, vecs[i].exp_be, vecs[i].exp_last);
    end
    check("table_drained", 64'(bus.buf_count), 64'd0);

    // Variable-length field then zero-length terminator.
    send(13, 64'h1FFF, 1'b1, 1'b0);
    check("var_no_beat", 64'(bus.out_valid), 64'd0);
    check("var_count",   64'(bus.buf_count), 64'd3);
    send(0, 64'h0, 1'b0, 1'b1);
    get_beat("var_term", 64'h0305_FCFC, 4'd4, 8'h0F, 1'b1);

    // Zero-length field with no flags writes nothing.
    send(0, 64'h0, 1'b0, 1'b0);
    check("empty_count", 64'(bus.buf_count), 64'd0);
    check("empty_valid", 64'(bus.out_valid), 64'd0);

    // Two buffered messages: the first eom closes the first beat.
    send(6, 64'h2A, 1'b0, 1'b1);
    send(12, 64'hABC, 1'b0, 1'b1);
    check("two_msg_count", 64'(bus.buf_count), 64'd3);
    get_beat("msg_a", 64'hAB, 4'd1, 8'h01, 1'b1);
    get_beat("msg_b", 64'hABF0, 4'd2, 8'h03, 1'b1);

    // in_len above DATA_WIDTH clamps to 64 bits -> 11 bytes.
    send(100, ONES, 1'b0, 1'b1);
    get_beat("clamp_a", FC8, 4'd8, 8'hFF, 1'b0);
    get_beat("clamp_b", 64'h3F_FCFC, 4'd3, 8'h07, 1'b1);

    // Flush of a partial, non-terminated message.
    send(13, 64'h1FFF, 1'b1, 1'b0);
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    get_beat("flush_beat", 64'h05_FCFC, 4'd3, 8'h07, 1'b0);
    check("flush_count",    64'(bus.buf_count), 64'd0);
    check("flush_done_rdy", 64'(bus.in_ready), 64'd1);
    check("flush_done_vld", 64'(bus.out_valid), 64'd0);

    // Flush with an empty buffer: one FLUSH cycle, no beat.
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    check("idle_flush_rdy", 64'(bus.in_ready), 64'd0);
    check("idle_flush_vld", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("idle_flush_back", 64'(bus.in_ready), 64'd1);

    // Backpressure: two 11-byte fields fill past the accept limit, beat holds.
    send(64, ONES, 1'b1, 1'b0);
    send(64, ONES, 1'b1, 1'b0);
    check("bp_count",    64'(bus.buf_count), 64'd22);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_valid",    64'(bus.out_valid), 64'd1);
    repeat (5) @(negedge clk);
    check("bp_hold_data", bus.out_data, FC8);
    check("bp_hold_len",  64'(bus.out_len), 64'(OB));
    check("bp_hold_rdy",  64'(bus.in_ready), 64'd0);
    get_beat("bp0", FC8, 4'd8, 8'hFF, 1'b0);
    send(64, ONES, 1'b0, 1'b1);   // lands across the pointer wrap
    get_beat("bp1", 64'hFCFC_FCFC_FC3D_FCFC, 4'd8, 8'hFF, 1'b0);
    get_beat("bp2", 64'hFCFC_3DFC_FCFC_FCFC, 4'd8, 8'hFF, 1'b0);
    get_beat("bp3", FC8, 4'd8, 8'hFF, 1'b0);
    get_beat("bp4", 64'h3F, 4'd1, 8'h01, 1'b1);
    check("bp_drained", 64'(bus.buf_count), 64'd0);

    // Reset mid-stream with 10 bytes buffered.
    send(60, ONES, 1'b1, 1'b0);
    check("pre_rst_count", 64'(bus.buf_count), 64'd10);
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(bus.buf_count), 64'd0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data",  bus.out_data, 64'd0);
    check("mid_rst_rdy",   64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(6, 64'h2A, 1'b0, 1'b1);
    get_beat("post_rst", 64'hAB, 4'd1, 8'h01, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dfd_te_mso_packer.md
Name: dfd_te_mso_packer

Overview:
- Sequential successor to the combinational MSEO/MDO encoder.
- Accepts one trace-message field per handshake and encodes it into MSEO/MDO bytes: MDO_BITS data bits in the upper bits of each byte, 2 MSEO bits in the lower bits.
- Buffers the encoded bytes and emits fixed-width output beats with valid/ready backpressure.
- Sits between the trace-encoder message builder and the trace funnel/sink.

Parameters:
- MDO_BITS, 6: data bits per output byte.
- DATA_WIDTH, 64: maximum field width in bits.
- OUT_BYTES, 8: bytes per output beat.
- BUF_BYTES, 32: byte-buffer depth. Must be a power of two and at least MAX_FIELD_BYTES + OUT_BYTES.
- Derived: MSG_BITS = MDO_BITS + 2.
- Derived: MAX_FIELD_BYTES = ceil(DATA_WIDTH / MDO_BITS), which is 11 at the defaults.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  field valid.
- in_ready  out  1  field accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  field value, LSB first.
- in_len  in  $clog2(DATA_WIDTH)+1  field length in bits.
- in_is_var  in  1  field is variable length (end-of-field MSEO = 01).
- in_is_last  in  1  last field of the message (MSEO = 11); has priority over in_is_var.
- flush_req  in  1  pulse: drain all buffered bytes.
- out_valid  out  1  beat valid.
- out_ready  in  1  beat accepted when out_valid && out_ready.
- out_data  out  OUT_BYTES*MSG_BITS  byte 0 in the LSBs.
- out_be  out  OUT_BYTES  byte enables, contiguous from bit 0.
- out_len  out  $clog2(OUT_BYTES)+1  number of valid bytes in the beat.
- out_last  out  1  beat ends on a message's MSEO = 11 byte.
- buf_count  out  $clog2(BUF_BYTES)+1  bytes currently buffered.

Behaviour:
- Reset: in_ready = 0, out_valid = 0, out_data/out_be/out_len/out_last = 0, buf_count = 0, FSM = IDLE, read/write pointers = 0.
- Encoding:
  - Effective length L = min(in_len, DATA_WIDTH).
  - Data bits at positions >= L are masked to 0.
  - Byte count N = ceil(L / MDO_BITS).
  - Bytes 0..N-2 carry MSEO 00. Byte N-1 carries 11 if in_is_last, else 01 if in_is_var, else 00.
  - L = 0 with is_last or is_var: one byte with MDO = 0 and the terminating MSEO.
  - L = 0 with neither flag: the handshake completes and no bytes are written.
- Buffer:
  - Circular byte buffer, each entry tagged with a one-bit eom flag (set on the MSEO = 11 byte).
  - Write pointer and read pointer wrap modulo BUF_BYTES.
  - Write is registered; bytes are visible to the output one cycle after the handshake.
- in_ready:
  - in_ready = (FSM != FLUSH) && (buf_count <= BUF_BYTES - MAX_FIELD_BYTES).
  - Registered-state-only; it never depends on in_valid.
  - Back-to-back fields are accepted every cycle while space allows.
- Beat formation (from registered state): beat length = min(buf_count, OUT_BYTES, position of first eom byte + 1).
  - out_valid = 1 when any of these holds:
    - buf_count >= OUT_BYTES;
    - an eom byte lies within the first OUT_BYTES entries;
    - FSM == FLUSH and buf_count > 0.
  - A message end always closes the beat, so the next message starts at byte 0 of a new beat.
  - out_last = 1 exactly when the beat's final byte has eom set.
- Output stability: while out_valid && !out_ready, out_data, out_be, out_len and out_last hold stable.
- Simultaneous push and pop in one cycle: buf_count_next = buf_count + N - beat length. No bubble.
- FSM states:
  - IDLE: buf_count == 0. Goes to ACCUM on a write, or to FLUSH on flush_req.
  - ACCUM: goes to IDLE when buf_count_next == 0 and there is no flush. Goes to FLUSH on flush_req.
  - FLUSH: in_ready = 0. Partial beats without eom are emitted. Goes to IDLE when buf_count reaches 0. flush_req while in FLUSH is ignored.
  - flush_req in IDLE: FLUSH lasts one cycle with no beat emitted, then IDLE.
- Asynchronous reset mid-operation discards buffer contents. There is no partial output after reset.

Optional Feature:
- Macro: DFD_TE_MSO_IDLE_FILL_EN.
- Defined: a non-full beat is padded to OUT_BYTES with idle bytes {MDO = 0, MSEO = 11}. out_be is then all ones and out_len = OUT_BYTES; out_last is unchanged.
- Undefined: no padding. Unused bytes are 0 and out_be/out_len reflect the real byte count.

Decomposition:
- dfd_te_pkg gains:
  - localparam MSO_BITS = 2;
  - enum mseo_e {MSEO_NORM = 2'b00, MSEO_VAR = 2'b01, MSEO_LAST = 2'b11};
  - enum te_mso_pk_state_e {IDLE, ACCUM, FLUSH}.
- One sub-module: dfd_te_mso_field_enc. It is combinational: field in, MAX_FIELD_BYTES bytes out, plus N and the eom position. It is reused by other packers.

Test Plan (defaults unless stated):
- Single short field: L = 6, data = 0x2A, is_last = 1 -> one beat, out_data[7:0] = 0xAB, out_len = 1, out_be = 0x01, out_last = 1.
- Variable field then terminator: field 1 is L = 13, data = 0x1FFF, is_var = 1; field 2 is L = 0, is_last = 1 -> bytes 0xFC, 0xFC, 0x05, 0x03, out_len = 4, out_last = 1.
- Masking: data = 0xFF, L = 3, is_last = 1 -> byte 0x1F.
- Backpressure: out_ready = 0, stream L = 64 fields -> in_ready drops once buf_count > 21 and the beat holds stable. Release out_ready -> bytes are emitted in order with no loss or duplication across pointer wrap.
- Flush: a 13-bit is_var field, then flush_req -> beat of 3 bytes, out_last = 0, in_ready low until buf_count = 0. With IDLE_FILL_EN: out_len = 8 and bytes 3..7 = 0x03.
- Reset mid-stream: assert reset_n = 0 with buf_count = 10 -> all outputs 0 immediately, buf_count = 0, and the next field is encoded correctly.
